// File: rtl/div_sched_pkg.sv
// Shared constants for the round-robin divider scheduler: FSM state codes, default watchdog
// limit and an index-width helper.
package div_sched_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  localparam int unsigned DefaultTimeout = 64;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer, wrapping modulo N,
// and moves the pointer past the winner when advance is asserted.
module rr_arbiter
  import div_sched_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = idw(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] ptr_q;
  int unsigned   j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt_idx = IW'(j);
      end
    end
    if (any) gnt = N'(1) << gnt_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance && any) begin
      ptr_q <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/div_rr_scheduler.sv
// Shares one sequential divider between NREQ requesters: round-robin grant, one-cycle start,
// watchdog-bounded wait and a tagged, back-pressured response channel.
module div_rr_scheduler
  import div_sched_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = DefaultTimeout,
  localparam int unsigned IDW    = idw(NREQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_dividend_i,
  input  logic [NREQ*WIDTH-1:0] req_divisor_i,
  input  logic [NREQ-1:0]       req_rem_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [IDW-1:0]        rsp_id_o,
  output logic [WIDTH-1:0]      rsp_result_o,
  output logic                  rsp_error_o,
  output logic                  rsp_timeout_o,
  output logic                  div_start_o,
  output logic [WIDTH-1:0]      div_dividend_o,
  output logic [WIDTH-1:0]      div_divisor_o,
  output logic                  div_rem_o,
  input  logic                  div_busy_i,
  input  logic                  div_valid_i,
  input  logic [WIDTH-1:0]      div_result_i
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             any;
  logic             in_idle;
  logic [WIDTH-1:0] sel_dividend, sel_divisor;
  logic [WIDTH-1:0] dividend_q, divisor_q, result_q;
  logic             rem_q, error_q, timeout_q;
  logic [IDW-1:0]   id_q;
  logic [CW-1:0]    cnt_q;
  logic             cnt_last;

  assign in_idle      = (state_q == StIdle);
  assign sel_dividend = req_dividend_i[int'(gnt_idx) * WIDTH +: WIDTH];
  assign sel_divisor  = req_divisor_i[int'(gnt_idx) * WIDTH +: WIDTH];
  assign cnt_last     = (cnt_q == CW'(TIMEOUT - 1));

  rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .clk     (clk_i),
    .rst     (rst_i),
    .req     (req_valid_i),
    .advance (in_idle),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (any) state_d = (sel_divisor == '0) ? StResp : StIssue;
      StIssue: state_d = StWait;
      StWait:  if (div_valid_i || cnt_last) state_d = StResp;
      StResp:  if (rsp_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= 1'b0;
      id_q       <= '0;
      result_q   <= '0;
      error_q    <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (any) begin
            dividend_q <= sel_dividend;
            divisor_q  <= sel_divisor;
            rem_q      <= req_rem_i[gnt_idx];
            id_q       <= gnt_idx;
            result_q   <= '0;
            error_q    <= (sel_divisor == '0);
            timeout_q  <= 1'b0;
          end
        end
        StIssue: cnt_q <= '0;
        StWait: begin
          if (div_valid_i) begin
            result_q <= div_result_i;
            error_q  <= 1'b0;
          end else if (cnt_last) begin
            result_q  <= '0;
            error_q   <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Gate with reset so the accept pulse cannot leak out while reset is held.
  assign req_ready_o    = (in_idle && !rst_i) ? gnt : '0;
  assign rsp_valid_o    = (state_q == StResp);
  assign rsp_id_o       = id_q;
  assign rsp_result_o   = result_q;
  assign rsp_error_o    = error_q;
  assign rsp_timeout_o  = timeout_q;
  assign div_start_o    = (state_q == StIssue);
  assign div_dividend_o = dividend_q;
  assign div_divisor_o  = divisor_q;
  assign div_rem_o      = rem_q;

  a_idle_not_busy : assert property (@(posedge clk_i) disable iff (rst_i) in_idle |-> !div_busy_i);

endmodule

// File: tb/tb_div_rr_scheduler.sv
// Bench for div_rr_scheduler: directed table, corner-case sequences and randomized operations
// checked against a round-robin / arithmetic reference model, with a behavioural divider.
module tb_div_rr_scheduler;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        req_valid;
  logic [3:0]        req_ready;
  logic [127:0]      req_dividend, req_divisor;
  logic [3:0]        req_rem;
  logic              rsp_valid, rsp_ready;
  logic [1:0]        rsp_id;
  logic [31:0]       rsp_result;
  logic              rsp_error, rsp_timeout;
  logic              div_start, div_rem, div_busy, div_valid;
  logic [31:0]       div_dividend, div_divisor, div_result;

  logic [31:0] dvd [4];
  logic [31:0] dvs [4];
  logic        hang;
  int          ptr;
  int          cyc = 0;
  int          nstart = 0;
  logic        zero_start = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  assign req_dividend = {dvd[3], dvd[2], dvd[1], dvd[0]};
  assign req_divisor  = {dvs[3], dvs[2], dvs[1], dvs[0]};

  always #5 clk = ~clk;

  div_rr_scheduler #(
    .WIDTH   (WIDTH),
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_dividend_i (req_dividend),
    .req_divisor_i  (req_divisor),
    .req_rem_i      (req_rem),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_id_o       (rsp_id),
    .rsp_result_o   (rsp_result),
    .rsp_error_o    (rsp_error),
    .rsp_timeout_o  (rsp_timeout),
    .div_start_o    (div_start),
    .div_dividend_o (div_dividend),
    .div_divisor_o  (div_divisor),
    .div_rem_o      (div_rem),
    .div_busy_i     (div_busy),
    .div_valid_i    (div_valid),
    .div_result_i   (div_result)
  );

  // Behavioural divider: result valid WIDTH+1 cycles after the start edge; hang masks valid.
  int          dcnt;
  logic [31:0] dres;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt <= 0;
      dres <= '0;
    end else if (div_start) begin
      dcnt <= WIDTH + 1;
      dres <= (div_divisor == 0) ? 32'hFFFF_FFFF :
              div_rem ? div_dividend % div_divisor : div_dividend / div_divisor;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
    end
  end
  assign div_busy   = (dcnt != 0);
  assign div_valid  = (dcnt == 1) && !hang;
  assign div_result = div_valid ? dres : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && div_start) nstart <= nstart + 1;
    if (!rst && div_start && div_divisor == 0) zero_start <= 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] m, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (m[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for the grant of requester w, then for its response, and checks both.
  task automatic serve(input int w, input logic [31:0] exp_res, input logic exp_err,
                       input logic exp_to, input int hold);
    int   n, g, s0, exp_lat;
    logic extra, bad;
    exp_lat = exp_err ? (exp_to ? TIMEOUT + 2 : 1) : WIDTH + 3;
    if (hold > 0) rsp_ready = 1'b0;
    #1;
    n = 0;
    while (req_ready == 0 && n < 16) begin
      step();
      n++;
    end
    chk("grant", req_ready, 4'b0001 << w);
    g  = cyc;
    s0 = nstart;
    step();
    req_valid[w] = 1'b0;
    extra = 1'b0;
    n = 0;
    while (!rsp_valid && n < TIMEOUT + 20) begin
      if (req_ready != 0) extra = 1'b1;
      step();
      n++;
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("latency", cyc - g, exp_lat);
    chk("rsp_id", rsp_id, w);
    chk("rsp_result", rsp_result, exp_res);
    chk("rsp_error", rsp_error, exp_err);
    chk("rsp_timeout", rsp_timeout, exp_to);
    chk("no_grant_busy", extra, 0);
    chk("start_count", nstart - s0, (exp_err && !exp_to) ? 0 : 1);
    if (hold > 0) begin
      bad = 1'b0;
      for (int i = 0; i < hold; i++) begin
        step();
        if (!rsp_valid || rsp_result !== exp_res || rsp_id !== 2'(w) ||
            rsp_error !== exp_err || req_ready != 0) bad = 1'b1;
      end
      chk("hold_stable", bad, 0);
    end
    rsp_ready = 1'b1;
    step();
    chk("rsp_drop", rsp_valid, 0);
  endtask

  task automatic model_op(input logic [3:0] mask, input int hold);
    int          w;
    logic [31:0] r;
    logic        e, t;
    w = pick(mask, ptr);
    if (dvs[w] == 0) begin
      r = '0; e = 1'b1; t = 1'b0;
    end else if (hang) begin
      r = '0; e = 1'b1; t = 1'b1;
    end else begin
      r = req_rem[w] ? dvd[w] % dvs[w] : dvd[w] / dvs[w];
      e = 1'b0; t = 1'b0;
    end
    req_valid = mask;
    serve(w, r, e, t, hold);
    ptr = (w + 1) % NREQ;
  endtask

  task automatic fill_default();
    for (int k = 0; k < 4; k++) begin
      dvd[k] = 32'd1;
      dvs[k] = 32'd1;
    end
    req_rem = '0;
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_ctl"}, {req_ready, rsp_valid, rsp_id, rsp_error, rsp_timeout, div_start, div_rem},
        0);
    chk({name, "_data"}, {rsp_result, div_dividend}, 0);
    chk({name, "_dvs"}, div_divisor, 0);
  endtask

  typedef struct {
    logic [3:0]  mask;
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        rem;
    logic [31:0] res;
    logic        err;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'b0001, 0, 32'd100,        32'd7,   1'b0, 32'd14,         1'b0};
    tbl[1] = '{4'b1111, 1, 32'd100,        32'd0,   1'b0, 32'd0,          1'b1};
    tbl[2] = '{4'b1111, 2, 32'd100,        32'd7,   1'b1, 32'd2,          1'b0};
    tbl[3] = '{4'b1111, 3, 32'hFFFF_FFFF,  32'd16,  1'b0, 32'h0FFF_FFFF,  1'b0};
    tbl[4] = '{4'b1111, 0, 32'd12345,      32'd1,   1'b1, 32'd0,          1'b0};
    tbl[5] = '{4'b0100, 2, 32'd7,          32'd100, 1'b0, 32'd0,          1'b0};
    tbl[6] = '{4'b0011, 0, 32'd50,         32'd3,   1'b1, 32'd2,          1'b0};
    tbl[7] = '{4'b1001, 3, 32'd81,         32'd9,   1'b0, 32'd9,          1'b0};

    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    hang      = 1'b0;
    ptr       = 0;
    fill_default();
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    #2;
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      fill_default();
      dvd[tbl[i].id]     = tbl[i].a;
      dvs[tbl[i].id]     = tbl[i].b;
      req_rem[tbl[i].id] = tbl[i].rem;
      req_valid          = tbl[i].mask;
      serve(tbl[i].id, tbl[i].res, tbl[i].err, 1'b0, 0);
      ptr = (tbl[i].id + 1) % NREQ;
    end

    // Watchdog: the divider never answers, then the next request is still served.
    fill_default();
    dvd[1] = 32'd100; dvs[1] = 32'd7;
    hang = 1'b1;
    model_op(4'b0010, 0);
    hang = 1'b0;
    dvd[2] = 32'd999; dvs[2] = 32'd10;
    model_op(4'b0100, 0);

    // Back-pressure: response held for 10 cycles with another request pending.
    fill_default();
    dvd[0] = 32'd77; dvs[0] = 32'd5; dvd[1] = 32'd64; dvs[1] = 32'd8; req_rem[1] = 1'b1;
    model_op(4'b0011, 10);
    chk("next_grant_cycle", req_ready, 4'b0001 << pick(req_valid, ptr));
    model_op(req_valid, 0);

    // Reset in the middle of WAIT discards the operation and restarts the pointer.
    fill_default();
    dvd[2] = 32'd100; dvs[2] = 32'd7;
    req_valid = 4'b0100;
    #1;
    chk("pre_rst_grant", req_ready, 4'b0100);
    step();
    req_valid = 4'b0000;
    repeat (5) step();
    req_valid = 4'b1111;
    #3;
    rst = 1'b1;
    #1;
    chk_zero_outputs("mid_rst");
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    ptr = 0;
    model_op(4'b1111, 0);

    // Randomized operations against the reference model.
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 4; k++) begin
        dvd[k]     = $urandom;
        dvs[k]     = ($urandom_range(0, 7) == 0) ? 32'd0 :
                     ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom;
        req_rem[k] = 1'($urandom_range(0, 1));
      end
      hang = ($urandom_range(0, 9) == 0);
      model_op(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)));
      hang = 1'b0;
    end

    chk("div_zero_start", zero_start, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
